wb_daq_dma_engine: RTL and testbench
====================================

// Module: wb_daq_dma_engine
// PURPOSE
//  N-channel DAQ-to-memory DMA engine: round-robin arbitration, per-channel ring-buffer address pointers, Wishbone burst write master.
//  Sits between the per-channel sample FIFOs and the system Wishbone bus; successor to the fixed 4-channel arbiter + bus-master pair.
//  Adds parametrised channel count, ring wrap, retry/error handling.
// PARAMETERS
//  NUM_CHANNELS  4   number of requesting channels (2..16)
//  DW            32  Wishbone/sample data width (32 only; sel fixed 4'hF)
//  AW            32  Wishbone address width
//  BURST_LEN     8   words moved per grant (1..64)
//  SIZE_W        16  width of per-channel ring size (in words)
// PORTS
//  wb_clk      in   1                  system clock; sole clock
//  wb_rst      in   1                  synchronous, active-high reset
//  enable      in   1                  master enable; 0 = no new grants
//  ch_req      in   NUM_CHANNELS       level: channel FIFO holds >= BURST_LEN words
//  ch_data_i   in   NUM_CHANNELS*DW    FWFT FIFO heads, channel k at [k*DW +: DW]
//  ch_base_i   in   NUM_CHANNELS*AW    ring base byte address, word aligned
//  ch_size_i   in   NUM_CHANNELS*SIZE_W  ring size in words; 0 = channel disabled
//  err_clr     in   NUM_CHANNELS       pulse: clears sticky ch_err[k], resets ptr[k] to 0
//  ch_pop      out  NUM_CHANNELS       one-hot pop strobe, one per acked beat
//  ch_wrap     out  NUM_CHANNELS       1-cycle pulse when ptr[k] wraps to 0
//  ch_err      out  NUM_CHANNELS       sticky bus-error flag per channel
//  busy        out  1                  high while a burst is in flight
//  grant_ch    out  clog2(NUM_CHANNELS)  index of current/last granted channel
//  wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o/wb_cyc_o/wb_stb_o/wb_cti_o/wb_bte_o  out  Wishbone B3 master
//  wb_ack_i/wb_err_i/wb_rty_i  in  1  Wishbone responses
// BEHAVIOUR
//  Reset: all outputs 0, ptr[*]=0, grant_ch=0 (rr pointer so channel 0 wins first), state IDLE.
//  Reset mid-burst drops cyc/stb on the same edge; no pop issued.
//  FSM:
//   IDLE -> ARB when enable && any eligible ch_req.
//     Eligible = ch_req[k] && !ch_err[k] && ch_size[k]!=0.
//   ARB (1 cycle) latches winner; round-robin search starts at grant_ch+1 and wraps modulo NUM_CHANNELS -> XFER.
//   XFER: cyc=stb=we=1, sel=4'hF.
//     adr = base[g] + (ptr[g]<<2); dat_o = ch_data_i[g] (combinational from FIFO head).
//   ack: ch_pop[g]=1 same cycle; ptr increments; beat counter increments.
//     ptr==size-1 -> ptr=0 and ch_wrap[g] pulses.
//     Last beat (beat==BURST_LEN-1) acked -> IDLE; cyc/stb drop next cycle.
//   rty: no pop, no ptr change; drop stb one cycle, then reissue the same beat.
//   err: no pop; ch_err[g]<=1; cyc/stb drop next cycle -> IDLE; remaining beats abandoned.
//     An errored channel is never granted until err_clr.
//  ack and err together: err wins. err_clr coincident with grant of that channel: clear applies, channel ineligible until next ARB.
//  enable low mid-burst: burst completes; no further grants.
//  Throughput: one beat per cycle with zero-wait slave; 1 idle + 1 ARB cycle between bursts.
// CONFIGURATION
//  WB_DAQ_DMA_BURST_EN defined:
//    cti=3'b010 (incrementing) on beats 0..BURST_LEN-2, 3'b111 on the last; bte=2'b00.
//    BURST_LEN=1 emits 3'b111 only.
//  Undefined: classic cycles, cti=3'b000, bte=2'b00.
//    cyc stays high for the whole group; stb deasserts 1 cycle after each ack.
// STRUCTURE
//  wb_daq_pkg: FSM state encoding (IDLE/ARB/XFER), CTI constants (CLASSIC/INCR/EOB), clog2 function.
//  Sub-module wb_daq_rr_arbiter #(N): request/eligible vector, rr pointer, advance strobe -> grant index + valid.
//  Per-channel ptr/err registers generated with a for-generate loop in the top.
// TESTING
//  1. ch_req=4'b0001, base0=0x1000, size0=64, zero-wait slave -> 8 writes 0x1000..0x101C, 8 pops, busy 8 cycles.
//  2. ch_req=4'b1111 held -> grants 0,1,2,3,0 in order; each burst 8 beats.
//  3. size0=12, two bursts on ch0 -> second burst adr 0x1020..0x102C then 0x1000..0x100C; ch_wrap[0] one pulse at wrap beat.
//  4. wb_rty_i on beat 3 of ch1 -> beat 3 reissued at same adr/data; total pops=8.
//  5. wb_err_i on beat 5 of ch2 -> 5 pops, ch_err[2]=1, ch2 skipped; after err_clr[2] it is granted again with ptr=0.
//  6. wb_rst asserted on beat 4 -> cyc=stb=0 next edge, all ptr=0; with/without WB_DAQ_DMA_BURST_EN check cti 010..111 vs 000.

Source files
------------

// File: rtl/wb_daq_pkg.sv
// Shared types and constants for the DAQ-to-Wishbone DMA engine.
package wb_daq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_daq_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner and wraps.
module wb_daq_rr_arbiter
    import wb_daq_pkg::*;
#(
    parameter  int N  = 4,
    localparam int GW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  elig,
    input  logic          advance,
    output logic [GW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [GW-1:0] last;
    logic [GW-1:0] cand;

    // Starting at N-1 lets channel 0 win the first arbitration after reset.
    always_ff @(posedge clk) begin
        if (rst)
            last <= GW'(N - 1);
        else if (advance && gnt_vld)
            last <= gnt_idx;
    end

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = GW'((int'(last) + i) % N);
            if (!gnt_vld && elig[cand]) begin
                gnt_idx = cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_daq_dma_engine.sv
// N-channel DAQ ring-buffer DMA writing to Wishbone; round-robin grants of BURST_LEN beats.
// Define WB_DAQ_DMA_BURST_EN for incrementing-burst cycles (cti 010/111); otherwise classic cycles.
module wb_daq_dma_engine
    import wb_daq_pkg::*;
#(
    parameter  int NUM_CHANNELS = 4,
    parameter  int DW           = 32,
    parameter  int AW           = 32,
    parameter  int BURST_LEN    = 8,
    parameter  int SIZE_W       = 16,
    localparam int GW           = clog2(NUM_CHANNELS),
    localparam int BW           = clog2(BURST_LEN + 1)
) (
    input  logic                           wb_clk,
    input  logic                           wb_rst,
    input  logic                           enable,
    input  logic [NUM_CHANNELS-1:0]        ch_req,
    input  logic [NUM_CHANNELS*DW-1:0]     ch_data_i,
    input  logic [NUM_CHANNELS*AW-1:0]     ch_base_i,
    input  logic [NUM_CHANNELS*SIZE_W-1:0] ch_size_i,
    input  logic [NUM_CHANNELS-1:0]        err_clr,
    output logic [NUM_CHANNELS-1:0]        ch_pop,
    output logic [NUM_CHANNELS-1:0]        ch_wrap,
    output logic [NUM_CHANNELS-1:0]        ch_err,
    output logic                           busy,
    output logic [GW-1:0]                  grant_ch,
    output logic [AW-1:0]                  wb_adr_o,
    output logic [DW-1:0]                  wb_dat_o,
    output logic [DW/8-1:0]                wb_sel_o,
    output logic                           wb_we_o,
    output logic                           wb_cyc_o,
    output logic                           wb_stb_o,
    output logic [2:0]                     wb_cti_o,
    output logic [1:0]                     wb_bte_o,
    input  logic                           wb_ack_i,
    input  logic                           wb_err_i,
    input  logic                           wb_rty_i
);

    logic [NUM_CHANNELS-1:0][DW-1:0]     data_a;
    logic [NUM_CHANNELS-1:0][AW-1:0]     base_a;
    logic [NUM_CHANNELS-1:0][SIZE_W-1:0] size_a;
    logic [NUM_CHANNELS-1:0][SIZE_W-1:0] ptr;
    logic [NUM_CHANNELS-1:0]             elig, ack_sel, at_end;

    state_t        state;
    logic [BW-1:0] beat;
    logic [GW-1:0] arb_idx;
    logic          arb_vld, ack_beat, err_beat, last_beat;

    assign data_a = ch_data_i;
    assign base_a = ch_base_i;
    assign size_a = ch_size_i;

    // err outranks ack; a beat landing on the reset edge is not popped.
    assign ack_beat  = wb_stb_o && wb_ack_i && !wb_err_i && !wb_rst;
    assign err_beat  = wb_stb_o && wb_err_i && !wb_rst;
    assign last_beat = (beat == BW'(BURST_LEN - 1));

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
        logic [SIZE_W-1:0] ptr_q;
        logic              err_q;

        assign at_end[k]  = (ptr_q == size_a[k] - SIZE_W'(1));
        assign ack_sel[k] = ack_beat && (grant_ch == GW'(k));
        assign elig[k]    = ch_req[k] && !err_q && (size_a[k] != '0);

        always_ff @(posedge wb_clk) begin
            if (wb_rst || err_clr[k]) begin
                ptr_q <= '0;
                err_q <= 1'b0;
            end else begin
                if (ack_sel[k])
                    ptr_q <= at_end[k] ? '0 : ptr_q + SIZE_W'(1);
                if (err_beat && grant_ch == GW'(k))
                    err_q <= 1'b1;
            end
        end

        assign ptr[k]    = ptr_q;
        assign ch_err[k] = err_q;
    end

    wb_daq_rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
        .clk     (wb_clk),
        .rst     (wb_rst),
        .elig    (elig),
        .advance (state == S_ARB),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state    <= S_IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            beat     <= '0;
            grant_ch <= '0;
        end else begin
            case (state)
                S_IDLE: if (enable && arb_vld) state <= S_ARB;
                S_ARB: begin
                    if (arb_vld) begin
                        grant_ch <= arb_idx;
                        beat     <= '0;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b1;
                        state    <= S_XFER;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_XFER: begin
                    if (!wb_stb_o) begin
                        wb_stb_o <= 1'b1;
                    end else if (wb_err_i || (wb_ack_i && last_beat)) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        state    <= S_IDLE;
                    end else if (wb_ack_i) begin
                        beat <= beat + BW'(1);
`ifdef WB_DAQ_DMA_BURST_EN
                        wb_stb_o <= 1'b1;
`else
                        wb_stb_o <= 1'b0;
`endif
                    end else if (wb_rty_i) begin
                        wb_stb_o <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ch_pop   = ack_sel;
    assign ch_wrap  = ack_sel & at_end;
    assign busy     = wb_cyc_o;
    assign wb_adr_o = wb_cyc_o ? base_a[grant_ch] + AW'({ptr[grant_ch], 2'b00}) : '0;
    assign wb_dat_o = wb_cyc_o ? data_a[grant_ch] : '0;
    assign wb_sel_o = wb_cyc_o ? '1 : '0;
    assign wb_bte_o = 2'b00;
`ifdef WB_DAQ_DMA_BURST_EN
    assign wb_cti_o = !wb_cyc_o ? CTI_CLASSIC : (last_beat ? CTI_EOB : CTI_INCR);
`else
    assign wb_cti_o = CTI_CLASSIC;
`endif

endmodule

// File: tb/tb_wb_daq_dma_engine.sv
// Directed bench for wb_daq_dma_engine: reset, arbitration, ring wrap, retry, error, mid-burst reset.
module tb_wb_daq_dma_engine;

    logic        wb_clk = 1'b0;
    logic        wb_rst, enable;
    logic [3:0]  ch_req, err_clr;
    logic [31:0] data [4];
    logic [31:0] base [4];
    logic [15:0] size [4];
    logic [127:0] ch_data_i, ch_base_i;
    logic [63:0] ch_size_i;
    logic [3:0]  ch_pop, ch_wrap, ch_err;
    logic        busy;
    logic [1:0]  grant_ch;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    int checks = 0;
    int errors = 0;
    int exp_ptr [4];

    always #5 wb_clk = ~wb_clk;

    assign ch_data_i = {data[3], data[2], data[1], data[0]};
    assign ch_base_i = {base[3], base[2], base[1], base[0]};
    assign ch_size_i = {size[3], size[2], size[1], size[0]};

    wb_daq_dma_engine dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .ch_req(ch_req),
        .ch_data_i(ch_data_i), .ch_base_i(ch_base_i), .ch_size_i(ch_size_i),
        .err_clr(err_clr), .ch_pop(ch_pop), .ch_wrap(ch_wrap), .ch_err(ch_err),
        .busy(busy), .grant_ch(grant_ch), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_cti(input int b);
`ifdef WB_DAQ_DMA_BURST_EN
        return (b == 7) ? 3'b111 : 3'b010;
`else
        return 3'b000;
`endif
    endfunction

    task automatic wait_stb();
        for (int i = 0; i < 40 && wb_stb_o !== 1'b1; i++) @(negedge wb_clk);
        chk("stb_wait", wb_stb_o, 1);
    endtask

    // Plays a zero-wait slave for one granted burst; rty_b/err_b/rst_b pick a beat to disturb (-1 = none).
    task automatic do_burst(input int ch, input int rty_b, input int err_b, input int rst_b);
        int b, p, pops;
        bit retried;
        b = 0; pops = 0; retried = 0;
        wait_stb();
        chk("grant", grant_ch, ch);
        while (b < 8) begin
            wait_stb();
            p = exp_ptr[ch];
            chk("adr", wb_adr_o, base[ch] + p * 4);
            chk("dat", wb_dat_o, data[ch]);
            chk("cti", wb_cti_o, exp_cti(b));
            chk("sel_we_cyc_busy_bte", {wb_sel_o, wb_we_o, wb_cyc_o, busy, wb_bte_o}, 9'b1111_111_00);
            if (b == rst_b) begin
                wb_rst = 1'b1; wb_ack_i = 1'b1; #1;
                chk("rst_pop", ch_pop, 0);
                @(negedge wb_clk);
                wb_rst = 1'b0; wb_ack_i = 1'b0;
                chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
                for (int k = 0; k < 4; k++) exp_ptr[k] = 0;
                return;
            end else if (b == rty_b && !retried) begin
                wb_rty_i = 1'b1; #1;
                chk("rty_pop", ch_pop, 0);
                @(negedge wb_clk);
                wb_rty_i = 1'b0; retried = 1'b1;
                chk("rty_stb_drop", wb_stb_o, 0);
            end else if (b == err_b) begin
                wb_err_i = 1'b1; wb_ack_i = 1'b1; #1;
                chk("err_pop", ch_pop, 0);
                @(negedge wb_clk);
                wb_err_i = 1'b0; wb_ack_i = 1'b0;
                chk("err_flag", ch_err[ch], 1);
                chk("err_cyc", wb_cyc_o, 0);
                chk("err_pops", pops, err_b);
                return;
            end else begin
                wb_ack_i = 1'b1; #1;
                chk("pop", ch_pop, 64'd1 << ch);
                chk("wrap", ch_wrap, (p == int'(size[ch]) - 1) ? (64'd1 << ch) : 64'd0);
                pops++;
                @(negedge wb_clk);
                wb_ack_i = 1'b0;
                data[ch] = data[ch] + 1;
                exp_ptr[ch] = (p + 1) % int'(size[ch]);
                b++;
            end
        end
        chk("end_cyc", wb_cyc_o, 0);
        chk("pops", pops, 8);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst = 1'b1; enable = 1'b0; ch_req = '0; err_clr = '0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data[k] = 32'hA000_0000 + (k << 16);
            base[k] = 32'h1000 * (k + 1);
            size[k] = 16'd64;
            exp_ptr[k] = 0;
        end
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);
        chk("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, busy}, 0);
        chk("rst_grant", grant_ch, 0);
        chk("rst_flags", {ch_err, ch_pop, ch_wrap}, 0);
        chk("rst_adr", wb_adr_o, 0);

        // enable low: request present but no grant
        ch_req = 4'b0001;
        repeat (6) @(negedge wb_clk);
        chk("enable_low", {wb_cyc_o, busy}, 0);

        // single channel, 8 beats from 0x1000
        enable = 1'b1;
        do_burst(0, -1, -1, -1);
        ch_req = 4'b0000;

        // ring of 12 words: 0x1020..0x102C then wrap to 0x1000
        size[0] = 16'd12;
        ch_req = 4'b0001;
        do_burst(0, -1, -1, -1);
        ch_req = 4'b0000;

        // reset on beat 4 of a burst
        ch_req = 4'b0001;
        do_burst(0, -1, -1, 4);
        ch_req = 4'b0000;
        size[0] = 16'd64;
        @(negedge wb_clk);
        chk("post_rst_grant", grant_ch, 0);
        chk("post_rst_err", ch_err, 0);

        // all channels requesting; retry on ch1 beat 3, error on ch2 beat 5
        ch_req = 4'b1111;
        do_burst(0, -1, -1, -1);
        do_burst(1, 3, -1, -1);
        do_burst(2, -1, 5, -1);
        chk("err_vec", ch_err, 4'b0100);
        do_burst(3, -1, -1, -1);
        do_burst(0, -1, -1, -1);
        do_burst(1, -1, -1, -1);
        do_burst(3, -1, -1, -1);
        ch_req = 4'b0000;

        err_clr = 4'b0100;
        @(negedge wb_clk);
        err_clr = 4'b0000;
        chk("err_clr", ch_err, 0);
        exp_ptr[2] = 0;
        ch_req = 4'b0100;
        do_burst(2, -1, -1, -1);
        ch_req = 4'b0000;
        repeat (3) @(negedge wb_clk);
        chk("final_idle", {wb_cyc_o, wb_stb_o}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
